update_ij_index_gen: RTL and testbench

- Nested-loop index generator: an outer index i and an inner index j for a triangular sweep over num_elems elements.
- Inner sweep per i covers j = i+1 .. N-1. Consumers use the (i, j) pairs as addresses for pairwise processing (elimination / compare-swap engines).
- Outer and inner counters handshake internally:
  - each i update auto-starts an inner sweep;
  - the end of each inner sweep advances i.
- The consumer throttles the inner loop with en_j.

---
 rtl/update_ij_index_gen_if.sv | 25 ++
 rtl/update_ij_index_gen.sv | 117 +++++++++++
 tb/tb_update_ij_index_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/update_ij_index_gen_if.sv
// rtl/update_ij_index_gen_if.sv - start/enable/index bundle between update_ij_index_gen and its consumer
interface update_ij_index_gen_if #(
    parameter int SIZE_ADDR = 8
) ();
    logic                 i_start;
    logic [SIZE_ADDR-1:0] i_num_elems;
    logic                 i_en_j;
    logic                 o_en_i;
    logic [SIZE_ADDR-1:0] o_value_i;
    logic                 o_done_i;
    logic                 o_en_j;
    logic [SIZE_ADDR-1:0] o_value_j;
    logic                 o_done_j;
    logic                 o_busy;

    modport master (
        output i_start, i_num_elems, i_en_j,
        input  o_en_i, o_value_i, o_done_i, o_en_j, o_value_j, o_done_j, o_busy
    );

    modport slave (
        input  i_start, i_num_elems, i_en_j,
        output o_en_i, o_value_i, o_done_i, o_en_j, o_value_j, o_done_j, o_busy
    );
endinterface

// File: rtl/update_ij_index_gen.sv
// rtl/update_ij_index_gen.sv - triangular (i, j) pair generator; UPDATE_IJ_FULL_RANGE_EN selects the full N*N sweep
module update_ij_index_gen #(
    parameter int SIZE_ADDR = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    update_ij_index_gen_if.slave   bus
);
    typedef enum logic [1:0] {I_IDLE, I_ISSUE, I_WAIT, I_DONE} i_state_e;
    typedef enum logic [1:0] {J_IDLE, J_RUN, J_DONE} j_state_e;

    localparam logic [SIZE_ADDR-1:0] ONE   = 1;
    localparam logic [SIZE_ADDR:0]   ONE_W = 1;

    i_state_e             i_state_q, i_state_d;
    j_state_e             j_state_q, j_state_d;
    logic [SIZE_ADDR-1:0] i_q, i_d;
    logic [SIZE_ADDR-1:0] j_q, j_d;
    logic [SIZE_ADDR-1:0] n_q, n_d;
    logic                 j_start_q;

    // One extra bit so i = 2^SIZE_ADDR-1 cannot wrap into a false non-empty range
    logic [SIZE_ADDR:0]   n_ext, i_inc, j_inc, j_first;

    assign n_ext = {1'b0, n_q};
    assign i_inc = {1'b0, i_q} + ONE_W;
    assign j_inc = {1'b0, j_q} + ONE_W;

`ifdef UPDATE_IJ_FULL_RANGE_EN
    assign j_first = '0;
`else
    assign j_first = i_inc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_state_q <= I_IDLE;
            j_state_q <= J_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            n_q       <= '0;
            j_start_q <= 1'b0;
        end else begin
            i_state_q <= i_state_d;
            j_state_q <= j_state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            n_q       <= n_d;
            j_start_q <= (i_state_q == I_ISSUE);
        end
    end

    always_comb begin
        i_state_d = i_state_q;
        i_d       = i_q;
        n_d       = n_q;
        case (i_state_q)
            I_IDLE: begin
                if (bus.i_start) begin
                    n_d       = bus.i_num_elems;
                    i_d       = '0;
                    i_state_d = (bus.i_num_elems == '0) ? I_DONE : I_ISSUE;
                end
            end
            I_ISSUE: i_state_d = I_WAIT;
            I_WAIT: begin
                if (j_state_q == J_DONE) begin
                    if (i_inc == n_ext) begin
                        i_state_d = I_DONE;
                    end else begin
                        i_d       = i_q + ONE;
                        i_state_d = I_ISSUE;
                    end
                end
            end
            I_DONE:  i_state_d = I_IDLE;
            default: i_state_d = I_IDLE;
        endcase
    end

    // An empty inner range leaves j_q untouched so o_value_j keeps its last value
    always_comb begin
        j_state_d = j_state_q;
        j_d       = j_q;
        case (j_state_q)
            J_IDLE: begin
                if (j_start_q) begin
                    if (j_first >= n_ext) begin
                        j_state_d = J_DONE;
                    end else begin
                        j_d       = j_first[SIZE_ADDR-1:0];
                        j_state_d = J_RUN;
                    end
                end
            end
            J_RUN: begin
                if (bus.i_en_j) begin
                    if (j_inc == n_ext) begin
                        j_state_d = J_DONE;
                    end else begin
                        j_d = j_q + ONE;
                    end
                end
            end
            J_DONE:  j_state_d = J_IDLE;
            default: j_state_d = J_IDLE;
        endcase
    end

    assign bus.o_en_i    = (i_state_q == I_ISSUE);
    assign bus.o_value_i = i_q;
    assign bus.o_done_i  = (i_state_q == I_DONE);
    assign bus.o_busy    = (i_state_q != I_IDLE);
    assign bus.o_en_j    = (j_state_q == J_RUN) && bus.i_en_j;
    assign bus.o_value_j = j_q;
    assign bus.o_done_j  = (j_state_q == J_DONE);
endmodule

// File: tb/tb_update_ij_index_gen.sv
// tb/tb_update_ij_index_gen.sv - directed bench for update_ij_index_gen
module tb_update_ij_index_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    update_ij_index_gen_if #(.SIZE_ADDR(8)) bus ();
    update_ij_index_gen #(.SIZE_ADDR(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int pair_i[$];
    int pair_j[$];
    int pair_c[$];
    int en_i_c[$];
    int en_i_v[$];
    int done_j_c[$];
    int done_i_c;
    int busy_cnt;
    int exp_en_i_c[3] = '{1, 6, 10};
    int exp_pair_c[3] = '{3, 4, 8};
    int exp_done_j[3] = '{5, 9, 12};

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_en_i"}, int'(bus.o_en_i), 0);
        chk({tag, "_value_i"}, int'(bus.o_value_i), 0);
        chk({tag, "_done_i"}, int'(bus.o_done_i), 0);
        chk({tag, "_en_j"}, int'(bus.o_en_j), 0);
        chk({tag, "_value_j"}, int'(bus.o_value_j), 0);
        chk({tag, "_done_j"}, int'(bus.o_done_j), 0);
        chk({tag, "_busy"}, int'(bus.o_busy), 0);
    endtask

    // Start a sweep at edge 0 and record everything observed in cycles 1..budget
    task automatic sweep(input int n, input bit stall, input int inject_c, input int budget);
        bit in_row;
        int exp_j;
        in_row = 1'b0;
        exp_j = 0;
        pair_i.delete(); pair_j.delete(); pair_c.delete();
        en_i_c.delete(); en_i_v.delete(); done_j_c.delete();
        done_i_c = -1;
        busy_cnt = 0;
        @(negedge clk);
        bus.i_num_elems = n[7:0];
        bus.i_start = 1'b1;
        bus.i_en_j = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        for (int c = 1; c <= budget && done_i_c < 0; c++) begin
            @(negedge clk);
            bus.i_en_j = stall ? (c % 4 == 3) : 1'b1;
            if (c == inject_c) begin
                bus.i_start = 1'b1;
                bus.i_num_elems = 8'd2;
            end else begin
                bus.i_start = 1'b0;
            end
            #1;
            if (in_row) chk("hold_j", int'(bus.o_value_j), exp_j);
            if (bus.o_busy) busy_cnt++;
            if (bus.o_en_i) begin
                en_i_c.push_back(c);
                en_i_v.push_back(int'(bus.o_value_i));
            end
            if (bus.o_en_j) begin
                pair_i.push_back(int'(bus.o_value_i));
                pair_j.push_back(int'(bus.o_value_j));
                pair_c.push_back(c);
                exp_j = int'(bus.o_value_j) + 1;
                in_row = (exp_j < n);
            end
            if (bus.o_done_j) done_j_c.push_back(c);
            if (bus.o_done_i) done_i_c = c;
        end
        bus.i_start = 1'b0;
        bus.i_en_j = 1'b1;
        chk("sweep_finished", int'(done_i_c >= 0), 1);
    endtask

    task automatic check_pairs(input int n, input string tag);
        int k;
        int lo;
        k = 0;
        for (int i = 0; i < n; i++) begin
`ifdef UPDATE_IJ_FULL_RANGE_EN
            lo = 0;
`else
            lo = i + 1;
`endif
            for (int j = lo; j < n; j++) begin
                chk({tag, "_pair_i"}, (k < pair_i.size()) ? pair_i[k] : -1, i);
                chk({tag, "_pair_j"}, (k < pair_j.size()) ? pair_j[k] : -1, j);
                k++;
            end
        end
        chk({tag, "_pair_count"}, pair_i.size(), k);
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_num_elems = '0;
        bus.i_en_j = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

`ifndef UPDATE_IJ_FULL_RANGE_EN
        sweep(3, 1'b0, -1, 40);
        chk("n3_en_i_count", en_i_c.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk("n3_en_i_cycle", (k < en_i_c.size()) ? en_i_c[k] : -1, exp_en_i_c[k]);
            chk("n3_en_i_value", (k < en_i_v.size()) ? en_i_v[k] : -1, k);
            chk("n3_pair_cycle", (k < pair_c.size()) ? pair_c[k] : -1, exp_pair_c[k]);
            chk("n3_done_j_cycle", (k < done_j_c.size()) ? done_j_c[k] : -1, exp_done_j[k]);
        end
        chk("n3_done_i_cycle", done_i_c, 13);
        chk("n3_busy_cycles", busy_cnt, 13);
        check_pairs(3, "n3");
        @(negedge clk);
        #1 chk("n3_busy_after", int'(bus.o_busy), 0);
`endif

        sweep(5, 1'b1, 7, 400);
        check_pairs(5, "n5_stall");
        chk("n5_en_i_count", en_i_c.size(), 5);
        chk("n5_done_j_count", done_j_c.size(), 5);

        sweep(1, 1'b0, -1, 40);
        chk("n1_en_i_count", en_i_c.size(), 1);
        chk("n1_en_i_value", (en_i_v.size() > 0) ? en_i_v[0] : -1, 0);
        chk("n1_done_j_count", done_j_c.size(), 1);
        check_pairs(1, "n1");

        sweep(0, 1'b0, -1, 40);
        chk("n0_done_i_cycle", done_i_c, 1);
        chk("n0_en_i_count", en_i_c.size(), 0);
        chk("n0_en_j_count", pair_i.size(), 0);
        chk("n0_done_j_count", done_j_c.size(), 0);

        @(negedge clk);
        bus.i_num_elems = 8'd5;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        repeat (9) @(posedge clk);
        #3 chk("pre_reset_busy", int'(bus.o_busy), 1);
        rst_n = 1'b0;
        #1 chk_outputs_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        sweep(3, 1'b0, -1, 60);
        check_pairs(3, "after_reset");

`ifdef UPDATE_IJ_FULL_RANGE_EN
        chk("full_n3_en_i_count", en_i_c.size(), 3);
        chk("full_n3_done_j_count", done_j_c.size(), 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
